branch_cond_unit: RTL

Holds the architectural NZCV flag register fed by the 64-bit ALU/subtractor flag outputs, and resolves conditional branches (B.cond, CBZ, CBNZ) one cycle after request. Sits directly downstream of the ALU in the EX stage. Supplies a registered taken/not-taken decision to the fetch/PC-select logic. Flags from a flag-setting instruction in EX bypass to a branch evaluated in the same cycle, so SUBS→B.cond needs no stall.

---
 rtl/branch_pkg.sv | 36 +++
 rtl/cond_eval.sv | 37 +++
 rtl/branch_cond_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch condition unit: branch kinds,
// ARM condition codes and the bit positions of N, Z, C, V inside flags_q.
package branch_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_CBZ  = 2'd2,
        BR_CBNZ = 2'd3
    } br_type_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator: {N,Z,C,V} plus a 4-bit code
// gives taken. Codes come in complementary pairs; bit 0 inverts the base test.
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] nzcv,
    input  logic [3:0] cond,
    output logic       taken
);

    logic n, z, c, v;
    logic base;

    always_comb begin
        n    = nzcv[FLAG_N];
        z    = nzcv[FLAG_Z];
        c    = nzcv[FLAG_C];
        v    = nzcv[FLAG_V];
        base = 1'b0;
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        // AL and NV (1110/1111) are both unconditional, so no inversion there
        if (cond[0] && (cond[3:1] != 3'b111))
            taken = ~base;
        else
            taken = base;
    end

endmodule

// File: rtl/branch_cond_unit.sv
// EX-stage NZCV flag register with same-cycle flag bypass, registered
// B.cond/CBZ/CBNZ resolution and a saturating taken-branch counter.
module branch_cond_unit
    import branch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_set_flags,
    input  logic             ex_flush,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_carry_out,
    input  logic             alu_overflow,
    input  logic             br_valid,
    input  logic [1:0]       br_type,
    input  logic [3:0]       br_cond,
    input  logic             reg_zero,
    output logic [3:0]       flags_q,
    output logic             br_done,
    output logic             br_taken,
    output logic [CNT_W-1:0] taken_count,
    input  logic             cnt_clear
);

    logic [3:0]       flags_reg;
    logic             br_done_reg;
    logic             br_taken_reg;
    logic [CNT_W-1:0] count_reg;

    logic             flag_write;
    logic [3:0]       alu_flags;
    logic [3:0]       eff_flags;
    logic             accept;
    logic             cond_taken;
    logic             taken_next;
    logic [CNT_W-1:0] count_next;

    assign alu_flags  = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
    assign flag_write = ex_valid & ex_set_flags & ~ex_flush;
    // Bypass lets SUBS -> B.cond in the same cycle see the fresh flags
    assign eff_flags  = flag_write ? alu_flags : flags_reg;
    assign accept     = br_valid & ~ex_flush & (br_type != 2'd0);

    cond_eval u_cond_eval (
        .nzcv  (eff_flags),
        .cond  (br_cond),
        .taken (cond_taken)
    );

    always_comb begin
        taken_next = 1'b0;
        case (br_type_e'(br_type))
            BR_COND: taken_next = cond_taken;
            BR_CBZ:  taken_next = reg_zero;
            BR_CBNZ: taken_next = ~reg_zero;
            default: taken_next = 1'b0;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (cnt_clear)
            count_next = '0;
        else if (accept && taken_next && !(&count_reg))
            count_next = count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_reg    <= 4'b0000;
            br_done_reg  <= 1'b0;
            br_taken_reg <= 1'b0;
            count_reg    <= '0;
        end else begin
            if (flag_write)
                flags_reg <= alu_flags;
            br_done_reg  <= accept;
            br_taken_reg <= accept & taken_next;
            count_reg    <= count_next;
        end
    end

    assign flags_q     = flags_reg;
    assign br_done     = br_done_reg;
    assign br_taken    = br_taken_reg;
    assign taken_count = count_reg;

endmodule
